// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the RV32I fetch stage: next-PC selection, fetch handshake, misaligned-target trap.
// Optional macro BRANCH_STATS_EN adds saturating branch / taken-branch retirement counters.
module pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            is_branch,
    input  logic            branch_taken,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] branch_count,
    output logic [XLEN-1:0] taken_count
);

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            adv;
    logic            redirect;
    logic            misaligned;
    logic            trap_now;
    logic [XLEN-1:0] target;

    assign pc_plus4   = pc + XLEN'(4);
    assign adv        = (state == RUN) && fetch_valid && fetch_ready && !stall;
    assign misaligned = redirect && (target[1:0] != 2'b00);
    assign trap_now   = adv && misaligned;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        if (is_jalr) begin
            target   = (rs1_val + imm) & ~XLEN'(1);
            redirect = 1'b1;
        end else if (is_jal || (is_branch && branch_taken)) begin
            target   = pc + imm;
            redirect = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (trap_now) state_nxt = TRAP;
            TRAP:    state_nxt = TRAP;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state == RUN);
    end

    // A trapping redirect leaves pc on the offending instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pc <= RESET_PC;
        else if (adv && !misaligned) pc <= target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_trap <= 1'b0;
            trap_pc       <= '0;
        end else if (trap_now) begin
            misalign_trap <= 1'b1;
            trap_pc       <= target;
        end
    end

`ifdef BRANCH_STATS_EN
    logic count_branch;
    assign count_branch = adv && is_branch && !misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (count_branch) begin
            if (branch_count != '1)                 branch_count <= branch_count + XLEN'(1);
            if (branch_taken && taken_count != '1)  taken_count  <= taken_count + XLEN'(1);
        end
    end
`else
    assign branch_count = '0;
    assign taken_count  = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push the expected fetch address, a monitor checks each accepted fetch.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        is_branch;
    logic        branch_taken;
    logic        is_jal;
    logic        is_jalr;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        misalign_trap;
    logic [31:0] trap_pc;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

`ifdef BRANCH_STATS_EN
    localparam logic [31:0] EXP_BR = 32'd2;
    localparam logic [31:0] EXP_TK = 32'd1;
`else
    localparam logic [31:0] EXP_BR = 32'd0;
    localparam logic [31:0] EXP_TK = 32'd0;
`endif

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc(pc), .pc_plus4(pc_plus4),
        .is_branch(is_branch), .branch_taken(branch_taken), .is_jal(is_jal),
        .is_jalr(is_jalr), .imm(imm), .rs1_val(rs1_val),
        .misalign_trap(misalign_trap), .trap_pc(trap_pc),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fetch must match the oldest expected address.
    always @(negedge clk) begin
        if (rst_n && fetch_valid && fetch_ready && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got pc 0x%08h with empty scoreboard", pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("fetch_pc", pc, e);
                check("fetch_pc_plus4", pc_plus4, e + 32'd4);
            end
        end
    end

    task automatic set_flags(input logic br, input logic tk, input logic jal, input logic jalr,
                             input logic [31:0] im, input logic [31:0] rs1);
        is_branch = br; branch_taken = tk; is_jal = jal; is_jalr = jalr; imm = im; rs1_val = rs1;
    endtask

    // One accepted cycle: exp is the fetch address expected on pc during this cycle.
    task automatic issue(input logic [31:0] exp, input logic br, input logic tk, input logic jal,
                         input logic jalr, input logic [31:0] im, input logic [31:0] rs1);
        set_flags(br, tk, jal, jalr, im, rs1);
        fetch_ready = 1'b1;
        stall       = 1'b0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(negedge clk);
        check("boot_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        set_flags(0, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0000_0100);
        check("rst_pc_plus4", pc_plus4, 32'h0000_0104);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_trap", {31'b0, misalign_trap}, 32'd0);
        check("rst_trap_pc", trap_pc, 32'd0);
        check("rst_branch_count", branch_count, 32'd0);
        check("rst_taken_count", taken_count, 32'd0);
        release_reset();

        issue(32'h0000_0100, 0, 0, 0, 0, 32'h0, 32'h0);
        issue(32'h0000_0104, 0, 0, 0, 0, 32'h0, 32'h0);
        issue(32'h0000_0108, 0, 0, 1, 0, 32'h0000_00F8, 32'h0);
        issue(32'h0000_0200, 1, 1, 0, 0, 32'hFFFF_FFF0, 32'h0);
        issue(32'h0000_01F0, 0, 0, 1, 0, 32'h0000_0010, 32'h0);
        issue(32'h0000_0200, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0);
        issue(32'h0000_0204, 0, 0, 1, 0, 32'h0000_00FC, 32'h0);
        issue(32'h0000_0300, 0, 0, 1, 1, 32'h0000_0004, 32'h0000_1001);
        issue(32'h0000_1004, 0, 0, 0, 1, 32'h0000_0000, 32'h0000_0500);

        // fetch_ready low holds the request, then stall holds it identically.
        set_flags(0, 0, 1, 0, 32'h0000_0040, 32'h0);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("ready_hold_pc", pc, 32'h0000_0500);
            check("ready_hold_valid", {31'b0, fetch_valid}, 32'd1);
        end
        issue(32'h0000_0500, 0, 0, 1, 0, 32'h0000_0040, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_hold_pc", pc, 32'h0000_0540);
        end
        issue(32'h0000_0540, 0, 0, 1, 0, 32'h0000_0040, 32'h0);

        issue(32'h0000_0580, 0, 1, 0, 0, 32'h0000_0100, 32'h0);
        issue(32'h0000_0584, 0, 0, 0, 1, 32'h0000_0000, 32'hFFFF_FFFC);
        issue(32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0, 32'h0);
        issue(32'h0000_0000, 0, 0, 0, 0, 32'h0, 32'h0);
        check("wrap_no_trap", {31'b0, misalign_trap}, 32'd0);
        check("branch_count", branch_count, EXP_BR);
        check("taken_count", taken_count, EXP_TK);

        issue(32'h0000_0004, 0, 0, 1, 0, 32'h0000_03FC, 32'h0);
        issue(32'h0000_0400, 0, 0, 1, 0, 32'h0000_0006, 32'h0);
        check("trap_flag", {31'b0, misalign_trap}, 32'd1);
        check("trap_pc", trap_pc, 32'h0000_0406);
        check("trap_pc_frozen", pc, 32'h0000_0400);
        check("trap_fetch_valid", {31'b0, fetch_valid}, 32'd0);

        set_flags(1, 1, 1, 0, 32'h0000_0008, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("trap_sticky_pc", pc, 32'h0000_0400);
        check("trap_sticky_pc_val", trap_pc, 32'h0000_0406);
        check("trap_branch_count", branch_count, EXP_BR);

        #2 rst_n = 1'b0;
        #1;
        check("async_rst_trap", {31'b0, misalign_trap}, 32'd0);
        check("async_rst_trap_pc", trap_pc, 32'd0);
        check("async_rst_pc", pc, 32'h0000_0100);
        check("async_rst_valid", {31'b0, fetch_valid}, 32'd0);
        check("async_rst_count", branch_count, 32'd0);

        set_flags(0, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        release_reset();
        issue(32'h0000_0100, 0, 0, 0, 0, 32'h0, 32'h0);
        issue(32'h0000_0104, 0, 0, 0, 0, 32'h0, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
